// File: rtl/mult_div_sequencer_pkg.sv
// Shared ALU opcodes and sequencer FSM encoding
// for the iterative multiply/divide engine.
package mult_div_sequencer_pkg;

    localparam logic [3:0] ALU_MULT = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic int md_cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sign_magnitude_conv.sv
// Two's-complement magnitude / conditional negation helper,
// shared by operand conversion and result sign correction.
module sign_magnitude_conv
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    input  logic             negate_en,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    assign sign      = is_signed & value[WIDTH-1];
    assign magnitude = (sign | negate_en) ? -value : value;

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle shift-add multiplier / restoring divider
// producing LO (ALU_OUT) and HI (ALU_OUT2) for MULT/DIV.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [OPERAND_WIDTH-1:0] Operand1,
    input  logic [OPERAND_WIDTH-1:0] Operand2,
    input  logic                     mult_start,
    input  logic                     div_start,
    input  logic                     is_signed,
    output logic [OPERAND_WIDTH-1:0] ALU_OUT,
    output logic [OPERAND_WIDTH-1:0] ALU_OUT2,
    output logic                     mult_div_done,
    output logic                     busy,
    output logic                     div_by_zero
);

    localparam int W  = OPERAND_WIDTH;
    localparam int CW = md_cnt_width(W);

    md_state_t       state;
    logic [CW-1:0]   cnt;
    logic [3:0]      op_q;
    logic            sgn_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic            dz_q;
    logic [W-1:0]    raw_a_q;
    logic [W-1:0]    iter_op_q;
    logic [2*W-1:0]  acc;

    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            sign_a;
    logic            sign_b;

    logic [W-1:0]    mul_add;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_r;
    logic            div_ge;
    logic [2*W-1:0]  div_next;

    logic            fix_neg_q;
    logic            fix_neg_r;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic            prod_sign_unused;
    logic            quo_sign_unused;
    logic            rem_sign_unused;

    sign_magnitude_conv #(.WIDTH(W)) u_conv_a (
        .value     (Operand1),
        .is_signed (is_signed),
        .negate_en (1'b0),
        .magnitude (mag_a),
        .sign      (sign_a)
    );

    sign_magnitude_conv #(.WIDTH(W)) u_conv_b (
        .value     (Operand2),
        .is_signed (is_signed),
        .negate_en (1'b0),
        .magnitude (mag_b),
        .sign      (sign_b)
    );

    assign fix_neg_q = sgn_q & (neg_a_q ^ neg_b_q);
    assign fix_neg_r = sgn_q & neg_a_q;

    sign_magnitude_conv #(.WIDTH(2*W)) u_fix_prod (
        .value     (acc),
        .is_signed (1'b0),
        .negate_en (fix_neg_q),
        .magnitude (prod_fix),
        .sign      (prod_sign_unused)
    );

    sign_magnitude_conv #(.WIDTH(W)) u_fix_quo (
        .value     (acc[W-1:0]),
        .is_signed (1'b0),
        .negate_en (fix_neg_q),
        .magnitude (quo_fix),
        .sign      (quo_sign_unused)
    );

    sign_magnitude_conv #(.WIDTH(W)) u_fix_rem (
        .value     (acc[2*W-1:W]),
        .is_signed (1'b0),
        .negate_en (fix_neg_r),
        .magnitude (rem_fix),
        .sign      (rem_sign_unused)
    );

    // Multiply: carry lives in mul_sum and is shifted straight into HI.
    always_comb begin
        mul_add  = acc[0] ? iter_op_q : '0;
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, mul_add};
        mul_next = {mul_sum, acc[W-1:1]};
    end

    // Divide: {R,Q} shifted left; R gets an extra bit for the compare.
    always_comb begin
        div_r  = {acc[2*W-1:W], acc[W-1]};
        div_ge = div_r >= {1'b0, iter_op_q};
        if (div_ge) begin
            div_next = {div_r[W-1:0] - iter_op_q, acc[W-2:0], 1'b1};
        end else begin
            div_next = {div_r[W-1:0], acc[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            op_q          <= '0;
            sgn_q         <= 1'b0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            dz_q          <= 1'b0;
            raw_a_q       <= '0;
            iter_op_q     <= '0;
            acc           <= '0;
            ALU_OUT       <= '0;
            ALU_OUT2      <= '0;
            mult_div_done <= 1'b0;
            busy          <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            mult_div_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (mult_start || div_start) begin
                        op_q        <= mult_start ? ALU_MULT : ALU_DIV;
                        sgn_q       <= is_signed;
                        neg_a_q     <= sign_a;
                        neg_b_q     <= sign_b;
                        dz_q        <= ~mult_start & (Operand2 == '0);
                        raw_a_q     <= Operand1;
                        iter_op_q   <= mult_start ? mag_a : mag_b;
                        acc         <= {{W{1'b0}}, mult_start ? mag_b : mag_a};
                        cnt         <= CW'(W - 1);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    acc <= (op_q == ALU_MULT) ? mul_next : div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op_q == ALU_MULT) begin
                        ALU_OUT  <= prod_fix[W-1:0];
                        ALU_OUT2 <= prod_fix[2*W-1:W];
                    end else if (dz_q) begin
                        ALU_OUT     <= '1;
                        ALU_OUT2    <= raw_a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        ALU_OUT  <= quo_fix;
                        ALU_OUT2 <= rem_fix;
                    end
                    mult_div_done <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: arithmetic reference model with
// per-cycle compare, directed literal cases and random traffic.
module tb_mult_div_sequencer;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] ALU_OUT;
    logic [W-1:0] ALU_OUT2;
    logic         mult_div_done;
    logic         busy;
    logic         div_by_zero;

    mult_div_sequencer #(.OPERAND_WIDTH(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Operand1      (Operand1),
        .Operand2      (Operand2),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .is_signed     (is_signed),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT2      (ALU_OUT2),
        .mult_div_done (mult_div_done),
        .busy          (busy),
        .div_by_zero   (div_by_zero)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the MULT/DIV definitions.
    task automatic calc(input bit m, input logic [31:0] a,
                        input logic [31:0] b, input bit s,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output bit dz);
        logic [63:0] p;
        int sa;
        int sb;
        longint la;
        longint lb;
        dz = 1'b0;
        if (m) begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = 64'(la * lb);
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            lo = p[31:0];
            hi = p[63:32];
        end else if (b == 0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            dz = 1'b1;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'h0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                lo = 32'(sa / sb);
                hi = 32'(sa % sb);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Transaction-level model: remaining cycles until the result lands.
    logic [31:0] m_lo = '0;
    logic [31:0] m_hi = '0;
    bit          m_dz = 1'b0;
    bit          m_done = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    logic [31:0] p_lo = '0;
    logic [31:0] p_hi = '0;
    bit          p_dz = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_lo    = '0;
            m_hi    = '0;
            m_dz    = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_lo   = p_lo;
                    m_hi   = p_hi;
                    m_dz   = p_dz;
                    m_done = 1'b1;
                end
            end else if (mult_start || div_start) begin
                calc(mult_start, Operand1, Operand2, is_signed,
                     p_lo, p_hi, p_dz);
                m_dz   = 1'b0;
                m_left = W + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cmp lo", 64'(ALU_OUT), 64'(m_lo));
            chk("cmp hi", 64'(ALU_OUT2), 64'(m_hi));
            chk("cmp done", 64'(mult_div_done), 64'(m_done));
            chk("cmp busy", 64'(busy), 64'(m_left > 0));
            chk("cmp dz", 64'(div_by_zero), 64'(m_dz));
        end
    end

    task automatic apply(input bit m, input bit d, input logic [31:0] a,
                         input logic [31:0] b, input bit s);
        Operand1   = a;
        Operand2   = b;
        is_signed  = s;
        mult_start = m;
        div_start  = d;
    endtask

    task automatic go(input bit m, input bit d, input logic [31:0] a,
                      input logic [31:0] b, input bit s);
        @(posedge CLK);
        #1;
        apply(m, d, a, b, s);
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the bound).
    task automatic wait_done(input int first_cyc, output int lat,
                             output int nb);
        int cyc;
        cyc = first_cyc;
        lat = -1;
        nb  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (mult_div_done) begin
                lat = cyc;
                break;
            end
            if (busy) nb++;
            cyc++;
        end
    endtask

    task automatic expect_res(input string nm, input logic [31:0] lo,
                              input logic [31:0] hi, input bit dz);
        chk({nm, " lo"}, 64'(ALU_OUT), 64'(lo));
        chk({nm, " hi"}, 64'(ALU_OUT2), 64'(hi));
        chk({nm, " dz"}, 64'(div_by_zero), 64'(dz));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int lat;
    int nb;
    int dones;

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset lo", 64'(ALU_OUT), 64'h0);
        chk("reset hi", 64'(ALU_OUT2), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(mult_div_done), 64'h0);
        RST = 1'b0;

        go(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_done(1, lat, nb);
        chk("t1 latency", 64'(lat), 64'd34);
        chk("t1 busy cycles", 64'(nb), 64'd33);
        expect_res("t1", 32'h0000_0001, 32'hFFFF_FFFE, 0);

        go(1, 0, 32'hFFFF_FFFD, 32'd7, 1);
        wait_done(1, lat, nb);
        expect_res("t2 smul", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
        go(1, 0, 32'hFFFF_FFFD, 32'd7, 0);
        wait_done(1, lat, nb);
        expect_res("t2 umul", 32'hFFFF_FFEB, 32'h0000_0006, 0);

        go(0, 1, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(1, lat, nb);
        expect_res("t3 sdiv", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        go(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(1, lat, nb);
        expect_res("t3 ovf", 32'h8000_0000, 32'h0, 0);

        go(0, 1, 32'd100, 32'd0, 1);
        wait_done(1, lat, nb);
        chk("t4 latency", 64'(lat), 64'd34);
        expect_res("t4 sdz", 32'hFFFF_FFFF, 32'h0000_0064, 1);
        go(0, 1, 32'd100, 32'd0, 0);
        wait_done(1, lat, nb);
        expect_res("t4 udz", 32'hFFFF_FFFF, 32'h0000_0064, 1);

        go(1, 1, 32'd5, 32'd3, 0);
        repeat (9) @(posedge CLK);
        #1;
        apply(0, 1, 32'd77, 32'd0, 1);
        @(posedge CLK);
        #1;
        div_start = 1'b0;
        wait_done(11, lat, nb);
        chk("t5 latency", 64'(lat), 64'd34);
        expect_res("t5 prio", 32'd15, 32'd0, 0);
        apply(0, 1, 32'd9, 32'd4, 0);
        @(posedge CLK);
        #1;
        div_start = 1'b0;
        wait_done(1, lat, nb);
        chk("t5 b2b latency", 64'(lat), 64'd34);
        expect_res("t5 b2b", 32'd2, 32'd1, 0);
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (mult_div_done) dones++;
        end
        chk("t5 idle dones", 64'(dones), 64'd0);
        expect_res("t5 hold", 32'd2, 32'd1, 0);

        go(0, 1, 32'd1000, 32'd7, 0);
        repeat (11) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        expect_res("t6 abort", 32'd0, 32'd0, 0);
        chk("t6 busy", 64'(busy), 64'd0);
        dones = 0;
        repeat (60) begin
            @(negedge CLK);
            if (mult_div_done) dones++;
        end
        chk("t6 no done", 64'(dones), 64'd0);
        go(0, 1, 32'd9, 32'd4, 0);
        wait_done(1, lat, nb);
        expect_res("t6 after", 32'd2, 32'd1, 0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            #1;
            RST = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) < 3) begin
                apply($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      pick(), pick(), $urandom_range(0, 1) == 1);
            end else begin
                mult_start = 1'b0;
                div_start  = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        repeat (40) @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
